// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RISC-V M-extension unit:
// funct3 opcodes and the controller state encoding.
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU unit: shift-add multiply,
// restoring divide, one bit per cycle, with RISC-V div-by-zero/overflow results.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_valid,
  output logic            start_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            busy,
  output logic            result_valid,
  input  logic            result_ready,
  output logic [XLEN-1:0] result,
  output state_e          dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and flush cancels either transfer.

  localparam int CW = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   opa_q;
  logic [2*XLEN-1:0] acc_q;
  logic [XLEN-1:0]   rem_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, rneg_q;
  logic [XLEN-1:0]   result_q;

  logic              accept;
  logic              is_div, a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res;

  always_comb begin
    accept   = start_valid && (state_q == ST_IDLE) && !flush;
    is_div   = funct3[2];
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    a_neg    = a_signed && rs1_data[XLEN-1];
    b_neg    = b_signed && rs2_data[XLEN-1];
    a_mag    = a_neg ? -rs1_data : rs1_data;
    b_mag    = b_neg ? -rs2_data : rs2_data;
    div_zero = is_div && (rs2_data == '0);
    div_ovf  = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
               (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = funct3[1] ? rs1_data : '1;
    else          special_res = funct3[1] ? '0 : rs1_data;
  end

  // One multiply step: add multiplicand into the high half, shift right.
  logic [XLEN:0]     mul_add;
  logic [2*XLEN-1:0] mul_next;
  // One restoring-divide step: the quotient shifts into acc_q's low half
  // while the dividend bits shift out of its top.
  logic [XLEN:0]     rem_sh, rem_diff;
  logic              q_bit;
  logic [XLEN-1:0]   rem_next, quo_next;

  always_comb begin
    mul_add  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opa_q} : '0);
    mul_next = {mul_add, acc_q[XLEN-1:1]};
    rem_sh   = {rem_q, acc_q[XLEN-1]};
    rem_diff = rem_sh - {1'b0, opa_q};
    q_bit    = ~rem_diff[XLEN];
    rem_next = q_bit ? rem_diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    quo_next = {acc_q[XLEN-2:0], q_bit};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, quo_res, rem_res, fix_res;

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    mul_res = (op_q == F3_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    quo_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_res = rneg_q ? -rem_q : rem_q;
    if (!op_q[2])     fix_res = mul_res;
    else if (op_q[1]) fix_res = rem_res;
    else              fix_res = quo_res;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (start_valid) state_d = special ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == CW'(1)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: if (result_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Output decode
  always_comb begin
    start_ready  = (state_q == ST_IDLE);
    busy         = (state_q != ST_IDLE);
    result_valid = (state_q == ST_DONE);
    result       = result_q;
    dbg_state_o  = state_q;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= funct3;
      opa_q  <= is_div ? b_mag : a_mag;
      acc_q  <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      rem_q  <= '0;
      cnt_q  <= CW'(XLEN);
      neg_q  <= a_neg ^ b_neg;
      rneg_q <= a_neg;
      if (special) result_q <= special_res;
    end else if (!flush && state_q == ST_CALC) begin
      cnt_q <= cnt_q - CW'(1);
      if (op_q[2]) begin
        acc_q <= {{XLEN{1'b0}}, quo_next};
        rem_q <= rem_next;
      end else begin
        acc_q <= mul_next;
      end
    end else if (!flush && state_q == ST_FIX) begin
      result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit at XLEN = 32: results, latency, special cases,
// backpressure, flush and asynchronous reset.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start_valid = 1'b0;
  logic            start_ready;
  logic [2:0]      funct3 = '0;
  logic [XLEN-1:0] rs1_data = '0;
  logic [XLEN-1:0] rs2_data = '0;
  logic            flush = 1'b0;
  logic            busy;
  logic            result_valid;
  logic            result_ready = 1'b0;
  logic [XLEN-1:0] result;
  state_e          dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [XLEN-1:0] exp_q[$];

  typedef struct {
    logic [2:0]      f3;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] e;
    int              lat;
    string           tag;
  } vec_t;
  vec_t vecs[$];

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_valid  (start_valid),
    .start_ready  (start_ready),
    .funct3       (funct3),
    .rs1_data     (rs1_data),
    .rs2_data     (rs2_data),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result       (result),
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // Launch one operation at the next edge; scramble inputs right after it.
  task automatic launch(input logic [2:0] f3, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    @(negedge clk);
    funct3 = f3; rs1_data = a; rs2_data = b; start_valid = 1'b1;
    @(posedge clk);
    #1;
    start_valid = 1'b0;
    funct3 = 3'($urandom_range(0, 7));
    rs1_data = $urandom; rs2_data = $urandom;
  endtask

  // Called 1 time unit after the accept edge; returns the cycle number at
  // which result_valid is first seen (0 on timeout), stopping at that negedge.
  task automatic wait_valid(output int cyc);
    int c;
    c = 1;
    cyc = 0;
    while (c < 100) begin
      @(negedge clk);
      if (result_valid) begin
        cyc = c;
        break;
      end
      @(posedge clk);
      c++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int cyc;
    logic [XLEN-1:0] e;
    exp_q.push_back(v.e);
    launch(v.f3, v.a, v.b);
    wait_valid(cyc);
    check({v.tag, "_latency"}, XLEN'(cyc), XLEN'(v.lat));
    if (cyc != 0) begin
      e = exp_q.pop_front();
      check(v.tag, result, e);
      result_ready = 1'b1;
      @(posedge clk);
      #1 result_ready = 1'b0;
      @(negedge clk);
      check({v.tag, "_idle"}, XLEN'(start_ready), XLEN'(1));
    end else begin
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int cyc;
    int rv_seen;

    vecs.push_back(vec_t'{F3_MUL,    32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB, 34, "mul"});
    vecs.push_back(vec_t'{F3_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 34, "mulh"});
    vecs.push_back(vec_t'{F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34, "mulhsu"});
    vecs.push_back(vec_t'{F3_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, "mulhu"});
    vecs.push_back(vec_t'{F3_DIV,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 34, "div_neg"});
    vecs.push_back(vec_t'{F3_REM,    32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 34, "rem_neg"});
    vecs.push_back(vec_t'{F3_DIVU,   32'd100,      32'd7,        32'd14,       34, "divu"});
    vecs.push_back(vec_t'{F3_REMU,   32'd100,      32'd7,        32'd2,        34, "remu"});
    vecs.push_back(vec_t'{F3_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, "div_negdivisor"});
    vecs.push_back(vec_t'{F3_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34, "rem_negdivisor"});
    vecs.push_back(vec_t'{F3_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1,  "div_by0"});
    vecs.push_back(vec_t'{F3_DIVU,   32'd5,        32'd0,        32'hFFFFFFFF, 1,  "divu_by0"});
    vecs.push_back(vec_t'{F3_REMU,   32'd5,        32'd0,        32'd5,        1,  "remu_by0"});
    vecs.push_back(vec_t'{F3_REM,    32'd5,        32'd0,        32'd5,        1,  "rem_by0"});
    vecs.push_back(vec_t'{F3_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  "div_ovf"});
    vecs.push_back(vec_t'{F3_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  "rem_ovf"});

    // Reset state
    #1;
    check("rst_start_ready", XLEN'(start_ready), XLEN'(1));
    check("rst_busy", XLEN'(busy), XLEN'(0));
    check("rst_result_valid", XLEN'(result_valid), XLEN'(0));
    check("rst_result", result, '0);
    check("rst_state", XLEN'(dbg_state), XLEN'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Backpressure: DONE holds for 10 cycles while a request is offered
    launch(F3_DIVU, 32'd100, 32'd7);
    wait_valid(cyc);
    check("bp_latency", XLEN'(cyc), XLEN'(34));
    for (int i = 0; i < 10; i++) begin
      check("bp_result_stable", result, 32'd14);
      check("bp_start_ready", XLEN'(start_ready), XLEN'(0));
      check("bp_valid_held", XLEN'(result_valid), XLEN'(1));
      funct3 = F3_DIV; rs1_data = 32'd5; rs2_data = 32'd0; start_valid = 1'b1;
      @(negedge clk);
    end
    result_ready = 1'b1;
    @(posedge clk);
    #1 result_ready = 1'b0; start_valid = 1'b0;
    @(negedge clk);
    check("bp_retire_idle", XLEN'(start_ready), XLEN'(1));
    check("bp_no_accept", XLEN'(busy), XLEN'(0));
    check("bp_valid_drop", XLEN'(result_valid), XLEN'(0));

    // Flush in cycle 10 of CALC together with a special-case request
    launch(F3_MUL, 32'd3, 32'd5);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("fl_busy_before", XLEN'(busy), XLEN'(1));
    flush = 1'b1; start_valid = 1'b1;
    funct3 = F3_DIV; rs1_data = 32'd5; rs2_data = 32'd0;
    @(posedge clk);
    #1 flush = 1'b0; start_valid = 1'b0;
    @(negedge clk);
    check("fl_start_ready", XLEN'(start_ready), XLEN'(1));
    check("fl_busy", XLEN'(busy), XLEN'(0));
    rv_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) rv_seen++;
    end
    check("fl_no_valid", XLEN'(rv_seen), XLEN'(0));
    check("fl_result_kept", result, 32'd14);

    // Asynchronous reset mid-CALC
    launch(F3_DIV, 32'hFFFFFFF9, 32'd2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("ar_busy", XLEN'(busy), XLEN'(0));
    check("ar_result_valid", XLEN'(result_valid), XLEN'(0));
    check("ar_result", result, '0);
    check("ar_start_ready", XLEN'(start_ready), XLEN'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // Unit is usable again after reset
    run_vec(vec_t'{F3_MULHU, 32'h00010000, 32'h00010000, 32'd1, 34, "post_reset_mulhu"});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
